// File: rtl/store_controller.sv
// Store-side sequencer for the GEMM accelerator: streams the finished C tile
// from the accumulator to memory one row per cycle, then pulses done_store.
module store_controller #(
   parameter int ADDR_W = 32,
   parameter int SIZE_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              can_store,
   input  logic              mem_stall,
   input  logic [ADDR_W-1:0] tile_C_addr,
   input  logic [ADDR_W-1:0] tile_C_stride,
   input  logic [SIZE_W-1:0] msize,
   input  logic [SIZE_W-1:0] nsize,
   output logic              done_store,
   output logic              gen_addr_store,
   output logic [ADDR_W-1:0] next_row_addr_store,
   output logic              interface_en_store,
   output logic              interface_rdwr_store,
   output logic [SIZE_W-1:0] interface_control_store,
   output logic              accum_rd_en,
   output logic [SIZE_W-1:0] accum_rd_row,
   output logic              store_busy
);

   typedef enum logic [1:0] {IDLE, WRITE, EMPTY} state_t;

   state_t            state;
   logic [SIZE_W-1:0] row_q;
   logic [SIZE_W-1:0] msize_q;
   logic [SIZE_W-1:0] nsize_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] stride_q;
   logic              last_row;

   assign last_row = (row_q == (msize_q - SIZE_W'(1)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         row_q    <= '0;
         addr_q   <= '0;
         stride_q <= '0;
         msize_q  <= '0;
         nsize_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (can_store) begin
                  if (msize != '0) begin
                     addr_q   <= tile_C_addr;
                     stride_q <= tile_C_stride;
                     msize_q  <= msize;
                     nsize_q  <= nsize;
                     row_q    <= '0;
                     state    <= WRITE;
                  end else begin
                     state <= EMPTY;
                  end
               end
            end
            // A stalled cycle holds everything; the tile always runs to completion.
            WRITE: begin
               if (!mem_stall) begin
                  if (last_row) begin
                     state <= IDLE;
                  end else begin
                     addr_q <= addr_q + stride_q;
                     row_q  <= row_q + SIZE_W'(1);
                  end
               end
            end
            EMPTY:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs are forced low while rst is high so they drop in the reset cycle itself.
   always_comb begin
      done_store              = 1'b0;
      gen_addr_store          = 1'b0;
      next_row_addr_store     = '0;
      interface_en_store      = 1'b0;
      interface_rdwr_store    = 1'b0;
      interface_control_store = '0;
      accum_rd_en             = 1'b0;
      accum_rd_row            = '0;
      store_busy              = 1'b0;
      if (!rst) begin
         store_busy = (state != IDLE);
         case (state)
            IDLE: begin
               if (can_store && (msize != '0)) begin
                  gen_addr_store      = 1'b1;
                  next_row_addr_store = tile_C_addr;
                  accum_rd_en         = 1'b1;
               end
            end
            WRITE: begin
               if (!mem_stall) begin
                  interface_en_store      = 1'b1;
                  interface_rdwr_store    = 1'b1;
                  interface_control_store = nsize_q;
                  if (last_row) begin
                     done_store = 1'b1;
                  end else begin
                     gen_addr_store      = 1'b1;
                     next_row_addr_store = addr_q + stride_q;
                     accum_rd_en         = 1'b1;
                     accum_rd_row        = row_q + SIZE_W'(1);
                  end
               end
            end
            EMPTY:   done_store = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/store_controller.md
Name: store_controller

Overview:
- Store-side sequencer for the GEMM accelerator.
- Responds to `can_store` from the load/execute controller and writes the finished output tile C from the accumulator to memory, one row per cycle.
- Drives the `*_store` interface and address-generation signals that the load/execute controller forwards while it is in its STORE state.
- Signals completion with `done_store`.

Parameters:
- ADDR_W, 32, width of addresses and strides.
- SIZE_W, 5, width of msize/nsize and of row indices.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- can_store  in  1  store grant; high from the last compute cycle until done_store.
- mem_stall  in  1  memory interface cannot accept a write this cycle.
- tile_C_addr  in  ADDR_W  byte address of row 0 of tile C.
- tile_C_stride  in  ADDR_W  byte offset between consecutive C rows.
- msize  in  SIZE_W  number of rows to store.
- nsize  in  SIZE_W  elements per row.
- done_store  out  1  last row is being written this cycle, or the empty tile is finished.
- gen_addr_store  out  1  load next_row_addr_store into the address generator.
- next_row_addr_store  out  ADDR_W  address of the next row to write.
- interface_en_store  out  1  write request valid this cycle.
- interface_rdwr_store  out  1  1 = write.
- interface_control_store  out  SIZE_W  element count of the current request.
- accum_rd_en  out  1  read accumulator row accum_rd_row; data is valid next cycle.
- accum_rd_row  out  SIZE_W  accumulator row index.
- store_busy  out  1  state is not IDLE.

Behaviour:
- States: IDLE, WRITE, EMPTY. State and all registers reset asynchronously on rst: state=IDLE, row_q=0, addr_q=0, stride_q=0, msize_q=0, nsize_q=0.
- All outputs are combinational from state and registers. The default value of every output is 0 (never x). During and right after reset, every output is 0.
- IDLE, can_store=1, msize!=0:
  - Assert gen_addr_store=1 with next_row_addr_store=tile_C_addr.
  - Assert accum_rd_en=1 with accum_rd_row=0.
  - Capture addr_q=tile_C_addr, stride_q=tile_C_stride, msize_q, nsize_q; set row_q=0.
  - Go to WRITE.
- IDLE, can_store=1, msize==0: go to EMPTY; no strobes.
- IDLE, can_store=0: stay.
- EMPTY: done_store=1 for exactly one cycle, interface_en_store=0, then go to IDLE.
- WRITE, mem_stall=1: all strobes 0, done_store=0, registers hold, stay in WRITE.
- WRITE, mem_stall=0, row_q != msize_q-1:
  - interface_en_store=1, interface_rdwr_store=1, interface_control_store=nsize_q.
  - gen_addr_store=1, next_row_addr_store=addr_q+stride_q.
  - accum_rd_en=1, accum_rd_row=row_q+1.
  - Update addr_q+=stride_q and row_q+=1.
- WRITE, mem_stall=0, row_q == msize_q-1:
  - interface_en_store=1, interface_rdwr_store=1, interface_control_store=nsize_q.
  - done_store=1, gen_addr_store=0, accum_rd_en=0.
  - Go to IDLE.
- Latency:
  - Request for row r appears one cycle after its gen_addr_store and its accum_rd_en.
  - With no stalls, done_store appears msize cycles after the can_store accept cycle.
  - Exactly msize write requests per tile.
- Arithmetic: address addition is modulo 2^ADDR_W, so wrap-around is silent. The row compare is unsigned, SIZE_W bits.
- Inputs are sampled only in IDLE. Changes to tile_C_*, msize or nsize during WRITE have no effect.
- can_store dropping during WRITE is ignored; the tile always completes.
- can_store high in the cycle after done_store (back-to-back tiles) is accepted from IDLE normally. The new tile starts one idle cycle after done.
- rst mid-tile: the tile is abandoned; outputs are 0 in the same cycle as rst, since reset is asynchronous.

Test Plan:
- Basic: tile_C_addr=0x1000, stride=0x40, msize=4, nsize=8, single can_store pulse.
  - Accept cycle: gen_addr_store=1, next_row_addr_store=0x1000, accum_rd_row=0.
  - Next 4 cycles: interface_en_store=1, control=8.
  - next_row_addr_store over those cycles: 0x1040, 0x1080, 0x10C0, then gen_addr_store=0.
  - done_store=1 only on the 4th write.
- Stall: same tile as Basic with mem_stall=1 on the 2nd write cycle for 3 cycles.
  - Strobes are 0 during the stall; addresses resume at 0x1080.
  - Total of 4 writes; done_store comes 3 cycles late.
- msize=1: a single write to tile_C_addr, done_store=1 in the same cycle, no second gen_addr_store.
- msize=0: one-cycle done_store in EMPTY, interface_en_store never asserted, then back in IDLE.
- Wrap and back-to-back:
  - tile_C_addr=0xFFFFFFC0, stride=0x40, msize=2 gives a second-row address of 0x00000000.
  - can_store re-asserted right after done_store starts a new tile with freshly sampled inputs.
- Reset mid-tile: assert rst during the 2nd write of an msize=8 tile.
  - All outputs drop to 0 immediately and store_busy=0.
  - After release, a new can_store starts at row 0.
